// File: rtl/scaler_h_mc.sv
// ---------------------------------------------------------------------------
// scaler_h_mc
//   Multi-channel horizontal downscaler. Each line is resampled at a
//   fixed-point step latched at line start, using linear or
//   nearest-neighbour interpolation between the previous and current input
//   pixels. The output pipeline has a fixed 2-cycle latency
//   (stage 1: multiply, stage 2: round/add).
//
// Ports
//   clk, rst_n     clock (posedge) and asynchronous active-low reset
//   scale_step_h   source pixels per output pixel, Q(STEP_W-FRAC_W).FRAC_W
//   mode_i         0 = linear, 1 = nearest neighbour (latched at line start)
//   di_i           input pixel, channels packed {chN-1..ch0}
//   de_i           input pixel valid
//   hs_i, vs_i     line / frame start, qualified by de_i
//   do_o           output pixel, holds its value while de_o is low
//   de_o           output pixel valid
//   hs_o, vs_o     first output of a line / first line of a frame
//   pix_cnt_o      output count of the last completed line
//   err_o          current line runs with a clamped step (step < 1.0)
//   ovf_o          current line ran past 2**XW input pixels
//   dbg_state      FSM state (IDLE=0, ACTIVE=1, OVF=2)
//
// Handshake: there is no back-pressure. A pixel is transferred on every
// rising edge where de_i is high; an output is valid on every cycle where
// de_o is high, and the consumer must accept it in that cycle.
// ---------------------------------------------------------------------------
module scaler_h_mc #(
    parameter int DW     = 12,
    parameter int CH     = 1,
    parameter int FRAC_W = 12,
    parameter int STEP_W = 16,
    parameter int XW     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STEP_W-1:0]    scale_step_h,
    input  logic                 mode_i,
    input  logic [CH*DW-1:0]     di_i,
    input  logic                 de_i,
    input  logic                 hs_i,
    input  logic                 vs_i,
    output logic [CH*DW-1:0]     do_o,
    output logic                 de_o,
    output logic                 hs_o,
    output logic                 vs_o,
    output logic [XW-1:0]        pix_cnt_o,
    output logic                 err_o,
    output logic                 ovf_o,
    output logic [1:0]           dbg_state
);

    localparam int PW     = XW + FRAC_W;
    localparam int PROD_W = DW + 1 + FRAC_W;

    localparam logic [STEP_W-1:0] STEP_ONE =
        {{(STEP_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [PROD_W-1:0] RND_HALF =
        {{(PROD_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        OVF    = 2'd2
    } state_t;

    // line control state
    state_t              state;
    logic [STEP_W-1:0]   step_q;
    logic                mode_q;
    logic [PW-1:0]       pos_q;
    logic [XW-1:0]       idx_q;      // index of the pixel held in prev_q
    logic [CH*DW-1:0]    prev_q;
    logic [XW-1:0]       out_cnt_q;
    logic                first_pend; // next emitted output is the line's first
    logic                vs_pend;

    // stage 1
    logic                s1_valid;
    logic                s1_hs;
    logic                s1_vs;
    logic                s1_mode;
    logic                s1_near_cur;
    logic [CH*DW-1:0]    s1_prev;
    logic [CH*DW-1:0]    s1_cur;
    logic signed [PROD_W-1:0] s1_prod [CH];

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic              line_start;
    logic              px_active;
    logic              last_idx;
    logic              emit;
    logic              step_clamp;
    logic [XW-1:0]     pos_int;
    logic [FRAC_W-1:0] frac;
    logic [PW-1:0]     step_ext;

    assign line_start = de_i & hs_i;
    assign px_active  = de_i & ~hs_i & (state == ACTIVE);
    // the incoming pixel would need index 2**XW, which does not fit
    assign last_idx   = (idx_q == {XW{1'b1}});
    assign pos_int    = pos_q[PW-1:FRAC_W];
    assign frac       = pos_q[FRAC_W-1:0];
    // an output sits between prev (index idx_q) and cur when pos points at prev
    assign emit       = px_active & ~last_idx & (pos_int == idx_q);
    assign step_clamp = (scale_step_h < STEP_ONE);
    assign step_ext   = PW'(step_q);

    // -----------------------------------------------------------------------
    // Stage 1 datapath: per-channel (cur - prev) * frac
    // -----------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_d [CH];
    logic signed [DW:0]       diff_d [CH];
    logic signed [PROD_W-1:0] diff_ext [CH];
    logic signed [PROD_W-1:0] frac_ext;

    always_comb begin
        frac_ext = {{(PROD_W-FRAC_W){1'b0}}, frac};
        for (int c = 0; c < CH; c++) begin
            diff_d[c]   = $signed({1'b0, di_i[c*DW +: DW]}) -
                          $signed({1'b0, prev_q[c*DW +: DW]});
            diff_ext[c] = {{(PROD_W-DW-1){diff_d[c][DW]}}, diff_d[c]};
            prod_d[c]   = diff_ext[c] * frac_ext;
        end
    end

    // -----------------------------------------------------------------------
    // Line FSM and position tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step_q     <= '0;
            mode_q     <= 1'b0;
            pos_q      <= '0;
            idx_q      <= '0;
            prev_q     <= '0;
            out_cnt_q  <= '0;
            first_pend <= 1'b0;
            vs_pend    <= 1'b0;
            pix_cnt_o  <= '0;
            err_o      <= 1'b0;
            ovf_o      <= 1'b0;
        end else if (line_start) begin
            state      <= ACTIVE;
            step_q     <= step_clamp ? STEP_ONE : scale_step_h;
            err_o      <= step_clamp;
            mode_q     <= mode_i;
            pos_q      <= '0;
            idx_q      <= '0;
            prev_q     <= di_i;
            // outputs are counted when issued, so anything still in the
            // pipeline here already belongs to the old line's count
            pix_cnt_o  <= out_cnt_q;
            out_cnt_q  <= '0;
            ovf_o      <= 1'b0;
            vs_pend    <= vs_i;
            first_pend <= 1'b1;
        end else if (px_active) begin
            if (last_idx) begin
                state <= OVF;
                ovf_o <= 1'b1;
            end else begin
                idx_q  <= idx_q + 1'b1;
                prev_q <= di_i;
                if (emit) begin
                    pos_q      <= pos_q + step_ext;
                    out_cnt_q  <= out_cnt_q + 1'b1;
                    first_pend <= 1'b0;
                    if (first_pend) begin
                        vs_pend <= 1'b0;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1 registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_mode     <= 1'b0;
            s1_near_cur <= 1'b0;
            s1_prev     <= '0;
            s1_cur      <= '0;
            for (int c = 0; c < CH; c++) begin
                s1_prod[c] <= '0;
            end
        end else begin
            s1_valid <= emit;
            if (emit) begin
                s1_hs       <= first_pend;
                s1_vs       <= first_pend & vs_pend;
                s1_mode     <= mode_q;
                // frac >= 0.5 is exactly the top fractional bit
                s1_near_cur <= frac[FRAC_W-1];
                s1_prev     <= prev_q;
                s1_cur      <= di_i;
                for (int c = 0; c < CH; c++) begin
                    s1_prod[c] <= prod_d[c];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 datapath: round, add to prev, or pick nearest
    // -----------------------------------------------------------------------
    logic signed [PROD_W-1:0] rnd_d [CH];
    logic [PROD_W-1:0]        sum_d [CH];
    logic [CH*DW-1:0]         out_d;
    logic                     unused_sum_hi;

    always_comb begin
        out_d         = '0;
        unused_sum_hi = 1'b0;
        for (int c = 0; c < CH; c++) begin
            rnd_d[c] = (s1_prod[c] + RND_HALF) >>> FRAC_W;
            // the rounded result lies between prev and cur, so the low DW
            // bits of the sum are the final value and never saturate
            sum_d[c] = {{(PROD_W-DW){1'b0}}, s1_prev[c*DW +: DW]} + rnd_d[c];
            unused_sum_hi = unused_sum_hi ^ (^sum_d[c][PROD_W-1:DW]);
            if (s1_mode) begin
                out_d[c*DW +: DW] = s1_near_cur ? s1_cur[c*DW +: DW]
                                                : s1_prev[c*DW +: DW];
            end else begin
                out_d[c*DW +: DW] = sum_d[c][DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
            do_o <= '0;
        end else begin
            de_o <= s1_valid;
            hs_o <= s1_valid & s1_hs;
            vs_o <= s1_valid & s1_vs;
            if (s1_valid) begin
                do_o <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_scaler_h_mc.sv
// ---------------------------------------------------------------------------
// tb_scaler_h_mc
//   Directed bench for scaler_h_mc with three channels: ch0 ramp x*100,
//   ch1 constant 0xFFF, ch2 0xFFF minus the ramp. Expected outputs come from
//   a reference that evaluates output k directly at position k*S.
// ---------------------------------------------------------------------------
module tb_scaler_h_mc;

    localparam int DW = 12;
    localparam int CH = 3;
    localparam int FRAC_W = 12;
    localparam int STEP_W = 16;
    localparam int XW = 11;
    localparam int W = CH * DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [STEP_W-1:0] scale_step_h;
    logic              mode_i;
    logic [W-1:0]      di_i;
    logic              de_i;
    logic              hs_i;
    logic              vs_i;
    logic [W-1:0]      do_o;
    logic              de_o;
    logic              hs_o;
    logic              vs_o;
    logic [XW-1:0]     pix_cnt_o;
    logic              err_o;
    logic              ovf_o;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cap_d[$];
    logic         cap_hs[$];
    logic         cap_vs[$];
    int           cap_cyc[$];
    int           px_cyc[$];

    scaler_h_mc #(
        .DW(DW), .CH(CH), .FRAC_W(FRAC_W), .STEP_W(STEP_W), .XW(XW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scale_step_h(scale_step_h), .mode_i(mode_i),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .pix_cnt_o(pix_cnt_o), .err_o(err_o), .ovf_o(ovf_o), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (de_o) begin
            cap_d.push_back(do_o);
            cap_hs.push_back(hs_o);
            cap_vs.push_back(vs_o);
            cap_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus / reference ----------------
    function automatic int pix(input int ch, input int x);
        int r;
        r = (x * 100) & 12'hFFF;
        if (ch == 1) return 12'hFFF;
        if (ch == 2) return 12'hFFF - r;
        return r;
    endfunction

    function automatic logic [W-1:0] pix_word(input int x);
        logic [W-1:0] w;
        for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'(pix(c, x));
        return w;
    endfunction

    function automatic logic [W-1:0] model_word(input int k, input int s, input logic mode);
        logic [W-1:0] w;
        int p, idx, fr, a, b, r;
        p = k * s;
        idx = p >>> FRAC_W;
        fr = p & ((1 << FRAC_W) - 1);
        for (int c = 0; c < CH; c++) begin
            a = pix(c, idx);
            b = pix(c, idx + 1);
            if (mode) r = (fr >= 2048) ? b : a;
            else r = a + ((((b - a) * fr) + 2048) >>> FRAC_W);
            w[c*DW +: DW] = DW'(r);
        end
        return w;
    endfunction

    task automatic build_exp(input int n, input int s, input logic mode);
        int se;
        se = (s < 4096) ? 4096 : s;
        for (int k = 0; ((k * se) >>> FRAC_W) <= n - 2; k++) exp_q.push_back(model_word(k, se, mode));
    endtask

    task automatic clear_caps();
        exp_q.delete(); cap_d.delete(); cap_hs.delete(); cap_vs.delete();
        cap_cyc.delete(); px_cyc.delete();
    endtask

    task automatic send_px(input logic [W-1:0] d, input logic hs, input logic vs);
        @(posedge clk); #1;
        de_i = 1'b1; hs_i = hs; vs_i = vs; di_i = d;
        px_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        end
    endtask

    task automatic send_line(input int n, input int step, input logic mode,
                             input logic vs, input int gap);
        scale_step_h = STEP_W'(step);
        mode_i = mode;
        for (int x = 0; x < n; x++) send_px(pix_word(x), x == 0, (x == 0) ? vs : 1'b0);
        idle(gap);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; de_i = 0; hs_i = 0; vs_i = 0; di_i = '0;
        scale_step_h = '0; mode_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({de_o, hs_o, vs_o, err_o, ovf_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {de_o, hs_o, vs_o, err_o, ovf_o});
        end
        checks++;
        if (do_o !== '0) begin errors++; $display("FAIL reset_do got %h want 0", do_o); end
        checks++;
        if (pix_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", pix_cnt_o); end
    endtask

    task automatic test_linear();
        clear_caps();
        send_line(24, 6826, 1'b0, 1'b1, 5);
        build_exp(24, 6826, 1'b0);
        checks++;
        if (cap_d.size() !== 14) begin errors++; $display("FAIL lin_count got %0d want 14", cap_d.size()); end
        for (int k = 0; k < cap_d.size() && k < exp_q.size(); k++) begin
            checks++;
            if (cap_d[k] !== exp_q[k]) begin
                errors++; $display("FAIL lin_data[%0d] got %h want %h", k, cap_d[k], exp_q[k]);
            end
        end
        if (cap_d.size() >= 3) begin
            checks++;
            if ({cap_d[0][11:0], cap_d[1][11:0], cap_d[2][11:0]} !== {12'd0, 12'd167, 12'd333}) begin
                errors++; $display("FAIL lin_hand got %0d %0d %0d want 0 167 333",
                                   cap_d[0][11:0], cap_d[1][11:0], cap_d[2][11:0]);
            end
            checks++;
            if ({cap_hs[0], cap_vs[0], cap_hs[1], cap_vs[1]} !== 4'b1100) begin
                errors++; $display("FAIL lin_sync got %b want 1100", {cap_hs[0], cap_vs[0], cap_hs[1], cap_vs[1]});
            end
        end
    endtask

    task automatic test_nearest();
        clear_caps();
        send_line(24, 6826, 1'b1, 1'b0, 5);
        build_exp(24, 6826, 1'b1);
        checks++;
        if (pix_cnt_o !== 11'd14) begin errors++; $display("FAIL near_pixcnt got %0d want 14", pix_cnt_o); end
        checks++;
        if (cap_d.size() !== exp_q.size()) begin
            errors++; $display("FAIL near_count got %0d want %0d", cap_d.size(), exp_q.size());
        end
        for (int k = 0; k < cap_d.size() && k < exp_q.size(); k++) begin
            checks++;
            if (cap_d[k] !== exp_q[k]) begin
                errors++; $display("FAIL near_data[%0d] got %h want %h", k, cap_d[k], exp_q[k]);
            end
        end
        if (cap_d.size() >= 3) begin
            checks++;
            if ({cap_d[1][11:0], cap_d[2][11:0]} !== {12'd200, 12'd300}) begin
                errors++; $display("FAIL near_hand got %0d %0d want 200 300", cap_d[1][11:0], cap_d[2][11:0]);
            end
            checks++;
            if ({cap_hs[0], cap_vs[0]} !== 2'b10) begin
                errors++; $display("FAIL near_sync got %b want 10", {cap_hs[0], cap_vs[0]});
            end
        end
    endtask

    task automatic test_unity();
        clear_caps();
        send_line(24, 4096, 1'b0, 1'b0, 5);
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL unity_err got %b want 0", err_o); end
        checks++;
        if (cap_d.size() !== 23) begin errors++; $display("FAIL unity_count got %0d want 23", cap_d.size()); end
        for (int k = 0; k < cap_d.size() && k < 23; k++) begin
            checks++;
            if (cap_d[k] !== pix_word(k)) begin
                errors++; $display("FAIL unity_data[%0d] got %h want %h", k, cap_d[k], pix_word(k));
            end
            checks++;
            if (cap_cyc[k] - px_cyc[k+1] !== 2) begin
                errors++; $display("FAIL unity_latency[%0d] got %0d want 2", k, cap_cyc[k] - px_cyc[k+1]);
            end
        end
    endtask

    task automatic test_clamp();
        clear_caps();
        send_line(24, 2048, 1'b0, 1'b0, 5);
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL clamp_err got %b want 1", err_o); end
        checks++;
        if (cap_d.size() !== 23) begin errors++; $display("FAIL clamp_count got %0d want 23", cap_d.size()); end
        for (int k = 0; k < cap_d.size() && k < 23; k++) begin
            checks++;
            if (cap_d[k] !== pix_word(k)) begin
                errors++; $display("FAIL clamp_data[%0d] got %h want %h", k, cap_d[k], pix_word(k));
            end
        end
        clear_caps();
        send_line(24, 6826, 1'b0, 1'b0, 5);
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL clamp_err_clear got %b want 0", err_o); end
        checks++;
        if (pix_cnt_o !== 11'd23) begin errors++; $display("FAIL clamp_pixcnt got %0d want 23", pix_cnt_o); end
    endtask

    task automatic test_channels();
        int s;
        clear_caps();
        send_line(24, 6826, 1'b0, 1'b0, 5);
        checks++;
        if (cap_d.size() !== 14) begin errors++; $display("FAIL chan_count got %0d want 14", cap_d.size()); end
        for (int k = 0; k < cap_d.size(); k++) begin
            s = int'(cap_d[k][11:0]) + int'(cap_d[k][35:24]);
            checks++;
            if (cap_d[k][23:12] !== 12'hFFF) begin
                errors++; $display("FAIL chan_ch1[%0d] got %h want fff", k, cap_d[k][23:12]);
            end
            checks++;
            if (s < 4094 || s > 4096) begin
                errors++; $display("FAIL chan_sum[%0d] got %0d want 4095+/-1", k, s);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_caps();
        send_line(24, 4096, 1'b0, 1'b0, 0);
        send_line(24, 6826, 1'b0, 1'b0, 6);
        for (int k = 0; k < 23; k++) exp_q.push_back(pix_word(k));
        build_exp(24, 6826, 1'b0);
        checks++;
        if (pix_cnt_o !== 11'd23) begin errors++; $display("FAIL b2b_pixcnt got %0d want 23", pix_cnt_o); end
        checks++;
        if (cap_d.size() !== 37) begin errors++; $display("FAIL b2b_count got %0d want 37", cap_d.size()); end
        for (int k = 0; k < cap_d.size() && k < exp_q.size(); k++) begin
            checks++;
            if (cap_d[k] !== exp_q[k] || cap_hs[k] !== (k == 0 || k == 23)) begin
                errors++; $display("FAIL b2b_data[%0d] got %h hs %b want %h hs %b",
                                   k, cap_d[k], cap_hs[k], exp_q[k], (k == 0 || k == 23));
            end
        end
    endtask

    task automatic test_reset_midline();
        scale_step_h = 16'd2048;
        mode_i = 1'b0;
        for (int x = 0; x < 10; x++) send_px(pix_word(x), x == 0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        di_i = pix_word(10);
        #1;
        checks++;
        if ({de_o, do_o, err_o, pix_cnt_o} !== '0) begin
            errors++; $display("FAIL midrst_outputs got de %b do %h err %b cnt %0d want all 0",
                               de_o, do_o, err_o, pix_cnt_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_caps();
        for (int x = 11; x < 24; x++) send_px(pix_word(x), 1'b0, 1'b0);
        idle(5);
        checks++;
        if (cap_d.size() !== 0) begin errors++; $display("FAIL midrst_quiet got %0d outputs want 0", cap_d.size()); end
        clear_caps();
        send_line(24, 6826, 1'b0, 1'b1, 5);
        checks++;
        if (cap_d.size() !== 14) begin errors++; $display("FAIL midrst_count got %0d want 14", cap_d.size()); end
        if (cap_d.size() > 0) begin
            checks++;
            if ({cap_hs[0], cap_vs[0]} !== 2'b11) begin
                errors++; $display("FAIL midrst_sync got %b want 11", {cap_hs[0], cap_vs[0]});
            end
        end
        checks++;
        if (pix_cnt_o !== 11'd0) begin errors++; $display("FAIL midrst_pixcnt got %0d want 0", pix_cnt_o); end
    endtask

    task automatic test_overflow();
        clear_caps();
        send_line((1 << XW) + 4, 4096, 1'b0, 1'b0, 5);
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf_o); end
        checks++;
        if (cap_d.size() !== 2047) begin errors++; $display("FAIL ovf_count got %0d want 2047", cap_d.size()); end
        if (cap_d.size() > 0) begin
            checks++;
            if (cap_d[cap_d.size()-1] !== pix_word(2046)) begin
                errors++; $display("FAIL ovf_last got %h want %h", cap_d[cap_d.size()-1], pix_word(2046));
            end
        end
        clear_caps();
        send_line(4, 4096, 1'b0, 1'b0, 5);
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf_o); end
        checks++;
        if (pix_cnt_o !== 11'd2047) begin errors++; $display("FAIL ovf_pixcnt got %0d want 2047", pix_cnt_o); end
        checks++;
        if (cap_d.size() !== 3) begin errors++; $display("FAIL ovf_next_count got %0d want 3", cap_d.size()); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_nearest();
        test_unity();
        test_clamp();
        test_channels();
        test_back_to_back();
        test_reset_midline();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
